// File: rtl/shop_inventory_v.sv
// Command-driven shop inventory: user/login bookkeeping and per-item stock counts.
// Every accepted command walks IDLE -> DECODE -> EXEC -> RESP and returns an ASCII status.
module shop_inventory_v #(
    parameter int I_A_NUM_ASCII_CHARS = 7,
    parameter int O_A_NUM_ASCII_CHARS = 9,
    parameter int I_U_NUM_BITS        = 4,
    parameter int MAX_USERS           = 5,
    parameter int MAX_ITEMS           = 8,
    parameter int I_ITEM_NUM_BITS     = 3,
    parameter int QTY_BITS            = 8,
    parameter logic [I_A_NUM_ASCII_CHARS*8-1:0] CMD_KEY__LOGOUT      = (I_A_NUM_ASCII_CHARS*8)'("Logout"),
    parameter logic [I_A_NUM_ASCII_CHARS*8-1:0] CMD_KEY__LOGIN       = (I_A_NUM_ASCII_CHARS*8)'("Login"),
    parameter logic [I_A_NUM_ASCII_CHARS*8-1:0] CMD_KEY__ADD_USER    = (I_A_NUM_ASCII_CHARS*8)'("AddUsr"),
    parameter logic [I_A_NUM_ASCII_CHARS*8-1:0] CMD_KEY__DELETE_USER = (I_A_NUM_ASCII_CHARS*8)'("DelUsr"),
    parameter logic [I_A_NUM_ASCII_CHARS*8-1:0] CMD_KEY__ADD_ITEM    = (I_A_NUM_ASCII_CHARS*8)'("AddItem"),
    parameter logic [I_A_NUM_ASCII_CHARS*8-1:0] CMD_KEY__DELETE_ITEM = (I_A_NUM_ASCII_CHARS*8)'("DelItem"),
    parameter logic [I_A_NUM_ASCII_CHARS*8-1:0] CMD_KEY__BUY         = (I_A_NUM_ASCII_CHARS*8)'("Buy")
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic                             i_rdy,
    input  logic [I_U_NUM_BITS-1:0]          i_u,
    input  logic [I_A_NUM_ASCII_CHARS*8-1:0] i_a,
    input  logic [I_ITEM_NUM_BITS-1:0]       i_item,
    input  logic [QTY_BITS-1:0]              i_qty,
    output logic [O_A_NUM_ASCII_CHARS*8-1:0] o_a,
    output logic                             o_valid,
    output logic                             o_busy
);
    localparam int A_W = I_A_NUM_ASCII_CHARS * 8;
    localparam int O_W = O_A_NUM_ASCII_CHARS * 8;

    localparam logic [O_W-1:0] RESP_OK    = O_W'("OK");
    localparam logic [O_W-1:0] RESP_CMD   = O_W'("ERR_CMD");
    localparam logic [O_W-1:0] RESP_AUTH  = O_W'("ERR_AUTH");
    localparam logic [O_W-1:0] RESP_USER  = O_W'("ERR_USER");
    localparam logic [O_W-1:0] RESP_ITEM  = O_W'("ERR_ITEM");
    localparam logic [O_W-1:0] RESP_STOCK = O_W'("ERR_STOCK");
    localparam logic [MAX_USERS-1:0] UV_RESET = MAX_USERS'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        CMD_NONE     = 3'd0,
        CMD_LOGOUT   = 3'd1,
        CMD_LOGIN    = 3'd2,
        CMD_ADD_USER = 3'd3,
        CMD_DEL_USER = 3'd4,
        CMD_ADD_ITEM = 3'd5,
        CMD_DEL_ITEM = 3'd6,
        CMD_BUY      = 3'd7
    } cmd_t;

    state_t                      state_q, state_d;
    cmd_t                        cmd_q, cmd_d;
    logic [I_U_NUM_BITS-1:0]     u_q;
    logic [A_W-1:0]              a_q;
    logic [I_ITEM_NUM_BITS-1:0]  item_q;
    logic [QTY_BITS-1:0]         qty_q;
    logic                        logged_in_q, logged_in_d;
    logic [I_U_NUM_BITS-1:0]     cur_user_q, cur_user_d;
    logic [MAX_USERS-1:0]        user_valid_q, user_valid_d;
    logic [QTY_BITS-1:0]         stock_q [MAX_ITEMS];
    logic [QTY_BITS-1:0]         stock_d [MAX_ITEMS];
    logic [O_W-1:0]              o_a_q, resp_d;
    logic                        o_valid_q, o_busy_q;

    logic                        sel_uv_s;
    logic [QTY_BITS-1:0]         sel_stock_s;
    logic                        is_admin_s, user_in_range_s, user_slot_s, item_in_range_s;
    logic                        uv_wr_s, uv_wdata_s, stock_wr_s;
    logic [QTY_BITS-1:0]         stock_wdata_s;
    logic [QTY_BITS:0]           stock_sum_s;

    // Sequencer: one cycle per non-idle state, strobes while busy are dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = i_rdy ? ST_DECODE : ST_IDLE;
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC:   state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Key lookup over the full captured key width.
    always_comb begin
        cmd_d = CMD_NONE;
        if (a_q == CMD_KEY__LOGOUT)           cmd_d = CMD_LOGOUT;
        else if (a_q == CMD_KEY__LOGIN)       cmd_d = CMD_LOGIN;
        else if (a_q == CMD_KEY__ADD_USER)    cmd_d = CMD_ADD_USER;
        else if (a_q == CMD_KEY__DELETE_USER) cmd_d = CMD_DEL_USER;
        else if (a_q == CMD_KEY__ADD_ITEM)    cmd_d = CMD_ADD_ITEM;
        else if (a_q == CMD_KEY__DELETE_ITEM) cmd_d = CMD_DEL_ITEM;
        else if (a_q == CMD_KEY__BUY)         cmd_d = CMD_BUY;
        else                                  cmd_d = CMD_NONE;
    end

    // Command execution: checks in priority order; only error-free commands write.
    always_comb begin
        resp_d        = RESP_OK;
        logged_in_d   = logged_in_q;
        cur_user_d    = cur_user_q;
        uv_wr_s       = 1'b0;
        uv_wdata_s    = 1'b0;
        stock_wr_s    = 1'b0;
        stock_wdata_s = '0;
        sel_uv_s      = 1'b0;
        sel_stock_s   = '0;
        // Range-checked reads expressed as OR-muxes so out-of-range indices read as zero.
        for (int k = 0; k < MAX_USERS; k++) begin
            sel_uv_s = sel_uv_s | (user_valid_q[k] & (32'(u_q) == k));
        end
        for (int k = 0; k < MAX_ITEMS; k++) begin
            sel_stock_s = sel_stock_s | (stock_q[k] & {QTY_BITS{32'(item_q) == k}});
        end
        is_admin_s      = logged_in_q && (cur_user_q == '0);
        user_in_range_s = 32'(u_q) < MAX_USERS;
        user_slot_s     = user_in_range_s && (u_q != '0);
        item_in_range_s = 32'(item_q) < MAX_ITEMS;
        stock_sum_s     = {1'b0, sel_stock_s} + {1'b0, qty_q};
        case (cmd_q)
            CMD_LOGIN: begin
                if (logged_in_q)                          resp_d = RESP_AUTH;
                else if (!user_in_range_s || !sel_uv_s)   resp_d = RESP_USER;
                else begin
                    logged_in_d = 1'b1;
                    cur_user_d  = u_q;
                end
            end
            CMD_LOGOUT: begin
                if (!logged_in_q) resp_d = RESP_AUTH;
                else              logged_in_d = 1'b0;
            end
            CMD_ADD_USER, CMD_DEL_USER: begin
                if (!is_admin_s)                                      resp_d = RESP_AUTH;
                else if (!user_slot_s || (sel_uv_s == (cmd_q == CMD_ADD_USER))) resp_d = RESP_USER;
                else begin
                    uv_wr_s    = 1'b1;
                    uv_wdata_s = (cmd_q == CMD_ADD_USER);
                end
            end
            CMD_ADD_ITEM, CMD_DEL_ITEM: begin
                if (!is_admin_s)           resp_d = RESP_AUTH;
                else if (!item_in_range_s) resp_d = RESP_ITEM;
                else begin
                    stock_wr_s = 1'b1;
                    if (cmd_q == CMD_DEL_ITEM)     stock_wdata_s = '0;
                    else if (stock_sum_s[QTY_BITS]) stock_wdata_s = '1;
                    else                            stock_wdata_s = stock_sum_s[QTY_BITS-1:0];
                end
            end
            CMD_BUY: begin
                if (!logged_in_q)               resp_d = RESP_AUTH;
                else if (!item_in_range_s)      resp_d = RESP_ITEM;
                else if (qty_q > sel_stock_s)   resp_d = RESP_STOCK;
                else begin
                    stock_wr_s    = 1'b1;
                    stock_wdata_s = sel_stock_s - qty_q;
                end
            end
            default: resp_d = RESP_CMD;
        endcase
        for (int k = 0; k < MAX_USERS; k++) begin
            user_valid_d[k] = (uv_wr_s && (32'(u_q) == k)) ? uv_wdata_s : user_valid_q[k];
        end
        user_valid_d[0] = 1'b1;
        for (int k = 0; k < MAX_ITEMS; k++) begin
            stock_d[k] = (stock_wr_s && (32'(item_q) == k)) ? stock_wdata_s : stock_q[k];
        end
    end

    // State, captured command, database and registered outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            cmd_q        <= CMD_NONE;
            u_q          <= '0;
            a_q          <= '0;
            item_q       <= '0;
            qty_q        <= '0;
            logged_in_q  <= 1'b0;
            cur_user_q   <= '0;
            user_valid_q <= UV_RESET;
            for (int k = 0; k < MAX_ITEMS; k++) stock_q[k] <= '0;
            o_a_q        <= '0;
            o_valid_q    <= 1'b0;
            o_busy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            o_valid_q <= (state_d == ST_RESP);
            o_busy_q  <= (state_d != ST_IDLE);
            if (state_q == ST_IDLE && i_rdy) begin
                u_q    <= i_u;
                a_q    <= i_a;
                item_q <= i_item;
                qty_q  <= i_qty;
            end
            if (state_q == ST_DECODE) cmd_q <= cmd_d;
            if (state_q == ST_EXEC) begin
                logged_in_q  <= logged_in_d;
                cur_user_q   <= cur_user_d;
                user_valid_q <= user_valid_d;
                stock_q      <= stock_d;
                o_a_q        <= resp_d;
            end
        end
    end

    assign o_a     = o_a_q;
    assign o_valid = o_valid_q;
    assign o_busy  = o_busy_q;

endmodule

// File: tb/tb_shop_inventory_v.sv
// Bench for shop_inventory_v: directed scenarios then random commands against a string-level model.
module tb_shop_inventory_v;
    localparam int AW = 56;
    localparam int OW = 72;

    logic           clk = 1'b0;
    logic           rst;
    logic           rdy;
    logic [3:0]     u;
    logic [AW-1:0]  a;
    logic [3:0]     item;
    logic [7:0]     qty;
    logic [OW-1:0]  o_a;
    logic           o_valid;
    logic           o_busy;

    int checks = 0;
    int errors = 0;

    bit m_in;
    int m_user;
    bit m_valid [16];
    int m_stock [16];

    shop_inventory_v #(.I_ITEM_NUM_BITS(4)) dut (
        .i_clk(clk), .i_reset(rst), .i_rdy(rdy), .i_u(u), .i_a(a),
        .i_item(item), .i_qty(qty), .o_a(o_a), .o_valid(o_valid), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] str_bits(string s);
        logic [OW-1:0] r;
        r = '0;
        for (int i = 0; i < s.len(); i++) r = (r << 8) | OW'(s[i]);
        return r;
    endfunction

    task automatic check(string tag, logic [OW-1:0] obs, logic [OW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_in = 1'b0;
        m_user = 0;
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_stock[i] = 0;
        end
        m_valid[0] = 1'b1;
    endfunction

    // Reference behaviour: 5 user slots, 8 item slots, 8-bit saturating stock.
    function automatic string model(string key, int uu, int it, int q);
        bit admin;
        admin = m_in && (m_user == 0);
        if (key == "Login") begin
            if (m_in) return "ERR_AUTH";
            if (uu >= 5 || !m_valid[uu]) return "ERR_USER";
            m_in = 1'b1;
            m_user = uu;
            return "OK";
        end
        if (key == "Logout") begin
            if (!m_in) return "ERR_AUTH";
            m_in = 1'b0;
            return "OK";
        end
        if (key == "AddUsr" || key == "DelUsr" || key == "AddItem" || key == "DelItem") begin
            if (!admin) return "ERR_AUTH";
            if (key == "AddUsr") begin
                if (uu < 1 || uu >= 5 || m_valid[uu]) return "ERR_USER";
                m_valid[uu] = 1'b1;
                return "OK";
            end
            if (key == "DelUsr") begin
                if (uu < 1 || uu >= 5 || !m_valid[uu]) return "ERR_USER";
                m_valid[uu] = 1'b0;
                return "OK";
            end
            if (it >= 8) return "ERR_ITEM";
            if (key == "AddItem") m_stock[it] = (m_stock[it] + q > 255) ? 255 : m_stock[it] + q;
            else                  m_stock[it] = 0;
            return "OK";
        end
        if (key == "Buy") begin
            if (!m_in) return "ERR_AUTH";
            if (it >= 8) return "ERR_ITEM";
            if (q > m_stock[it]) return "ERR_STOCK";
            m_stock[it] = m_stock[it] - q;
            return "OK";
        end
        return "ERR_CMD";
    endfunction

    // One command with full handshake timing checks; fixed_exp overrides the model when non-empty.
    task automatic run(string key, int uu, int it, int q, string fixed_exp);
        string exp_s;
        exp_s = model(key, uu, it, q);
        if (fixed_exp != "") exp_s = fixed_exp;
        @(negedge clk);
        u = uu[3:0];
        a = AW'(str_bits(key));
        item = it[3:0];
        qty = q[7:0];
        rdy = 1'b1;
        @(posedge clk); #1;
        rdy = 1'b0;
        check({key, " busy_decode"}, OW'(o_busy), OW'(1'b1));
        check({key, " valid_decode"}, OW'(o_valid), OW'(1'b0));
        @(posedge clk); #1;
        check({key, " valid_exec"}, OW'(o_valid), OW'(1'b0));
        @(posedge clk); #1;
        check({key, " valid_resp"}, OW'(o_valid), OW'(1'b1));
        check({key, " resp"}, o_a, str_bits(exp_s));
        @(posedge clk); #1;
        check({key, " valid_after"}, OW'(o_valid), OW'(1'b0));
        check({key, " busy_idle"}, OW'(o_busy), OW'(1'b0));
        check({key, " resp_hold"}, o_a, str_bits(exp_s));
    endtask

    initial begin
        string keys [9];
        int nv;
        int k;
        int q;
        keys = '{"Logout", "Login", "AddUsr", "DelUsr", "AddItem", "DelItem", "Buy", "NONE", "hi"};
        rst = 1'b1; rdy = 1'b0; u = '0; a = '0; item = '0; qty = '0;
        model_reset();
        #1;
        check("reset_o_a", o_a, '0);
        check("reset_valid", OW'(o_valid), OW'(1'b0));
        check("reset_busy", OW'(o_busy), OW'(1'b0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        run("Login", 4, 0, 0, "ERR_USER");
        run("Login", 0, 0, 0, "OK");
        run("Login", 0, 0, 0, "ERR_AUTH");
        run("AddUsr", 4, 0, 0, "OK");
        run("AddUsr", 4, 0, 0, "ERR_USER");
        run("Logout", 0, 0, 0, "OK");
        run("Login", 4, 0, 0, "OK");
        run("AddItem", 0, 2, 10, "ERR_AUTH");
        run("Logout", 0, 0, 0, "OK");
        run("Login", 0, 0, 0, "OK");
        run("AddItem", 0, 2, 200, "OK");
        run("AddItem", 0, 2, 200, "OK");
        run("Buy", 0, 2, 255, "OK");
        run("Buy", 0, 2, 1, "ERR_STOCK");
        run("hi", 0, 0, 0, "ERR_CMD");
        run("NONE", 0, 0, 0, "ERR_CMD");
        run("AddItem", 0, 9, 1, "ERR_ITEM");
        run("Buy", 0, 9, 0, "ERR_ITEM");
        run("AddItem", 0, 7, 5, "OK");
        run("Buy", 0, 7, 0, "OK");
        run("Buy", 0, 7, 5, "OK");
        run("DelUsr", 0, 0, 0, "ERR_USER");
        run("DelUsr", 5, 0, 0, "ERR_USER");

        // Strobe held for four edges must produce exactly one response.
        void'(model("Buy", 0, 0, 0));
        @(negedge clk);
        u = 4'd0; a = AW'(str_bits("Buy")); item = 4'd0; qty = 8'd0; rdy = 1'b1;
        nv = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (o_valid) nv++;
        end
        rdy = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (o_valid) nv++;
        end
        check("held_rdy_valid_count", OW'(nv), OW'(1));
        check("held_rdy_resp", o_a, str_bits("OK"));

        // Reset pulsed while the command sits in DECODE aborts it.
        @(negedge clk);
        u = 4'd4; a = AW'(str_bits("Login")); item = 4'd0; qty = 8'd0; rdy = 1'b1;
        @(posedge clk); #1;
        rdy = 1'b0;
        check("abort_busy_decode", OW'(o_busy), OW'(1'b1));
        #2 rst = 1'b1;
        #1;
        check("abort_busy", OW'(o_busy), OW'(1'b0));
        check("abort_o_a", o_a, '0);
        #1 rst = 1'b0;
        model_reset();
        nv = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (o_valid) nv++;
        end
        check("abort_no_valid", OW'(nv), OW'(0));
        run("Login", 4, 0, 0, "ERR_USER");

        // Random commands scored against the model.
        for (int n = 0; n < 120; n++) begin
            k = int'($urandom_range(0, 8));
            q = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 255));
            if (keys[k] == "Login" && $urandom_range(0, 1) == 0)
                run("Login", 0, 0, 0, "");
            else
                run(keys[k], int'($urandom_range(0, 6)), int'($urandom_range(0, 9)), q, "");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
